// File: rtl/iq_sample_fifo.sv
// Show-ahead single-clock FIFO packing I/Q sample pairs into 32-bit words, with sticky overflow
// tracking. Define IQ_TEST_PATTERN_EN to replace incoming samples with a {r,~r} ramp pattern.
module iq_sample_fifo #(
    parameter int ADDR_W      = 10,
    parameter int AFULL_LEVEL = 896
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       in_i,
    input  logic [15:0]       in_q,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              rd_dr,
    output logic [ADDR_W:0]   level,
    output logic              afull,
    output logic              overflow,
    output logic [15:0]       ovf_count,
    input  logic              ovf_clear
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_LEVEL);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic [31:0]       wr_word;
    logic              full;
    logic              wr_go;
    logic              rd_go;
    logic              drop;

    assign full  = (level_q == FULL_LVL);
    assign wr_go = in_valid & ~full;
    assign drop  = in_valid & full;
    assign rd_go = rd_en & rd_dr;

`ifdef IQ_TEST_PATTERN_EN
    logic [15:0] ramp;
    logic        unused_iq;

    // Ramp advances on every offered sample, so host-side gaps reveal dropped samples too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ramp <= '0;
        else if (in_valid)
            ramp <= ramp + 16'd1;
    end

    assign wr_word   = {ramp, ~ramp};
    assign unused_iq = ^{in_i, in_q};
`else
    assign wr_word = {in_i, in_q};
`endif

    always_ff @(posedge clk) begin
        if (wr_go)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_go)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_go)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_go, rd_go})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clear restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clear)
                ovf_count <= 16'd1;
            else if (ovf_count != '1)
                ovf_count <= ovf_count + 16'd1;
        end else if (ovf_clear) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign rd_dr   = (level_q != '0);
    assign afull   = (level_q >= AFULL_LVL);
    assign level   = level_q;

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed self-checking bench for iq_sample_fifo; pattern-mode checks build when IQ_TEST_PATTERN_EN is defined.
module tb_iq_sample_fifo;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_dr;
    logic [10:0] level;
    logic        afull;
    logic        overflow;
    logic [15:0] ovf_count;
    logic        ovf_clear;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    int          mlevel = 0;
    logic        movf = 1'b0;
    int          mcnt = 0;
    logic [15:0] mramp = '0;

    iq_sample_fifo #(.ADDR_W(10), .AFULL_LEVEL(896)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_dr     (rd_dr),
        .level     (level),
        .afull     (afull),
        .overflow  (overflow),
        .ovf_count (ovf_count),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mlevel = 0;
        movf   = 1'b0;
        mcnt   = 0;
        mramp  = '0;
    endtask

    // Drives one cycle (called #1 after a posedge); leaves time at #1 after the next posedge.
    task automatic step(input logic v, input logic [15:0] i, input logic [15:0] q,
                        input logic re, input logic clr);
        logic [31:0] word;
        logic        acc;
        logic        pop;
        in_valid  = v;
        in_i      = i;
        in_q      = q;
        rd_en     = re;
        ovf_clear = clr;
`ifdef IQ_TEST_PATTERN_EN
        word = {mramp, ~mramp};
        if (v) mramp = mramp + 16'd1;
`else
        word = {i, q};
`endif
        acc = v && (mlevel < DEPTH);
        pop = re && (mlevel != 0);
        if (pop) begin
            check("pop_data", rd_data, mq[0]);
            void'(mq.pop_front());
        end
        if (acc) mq.push_back(word);
        if (v && !acc) begin
            movf = 1'b1;
            if (clr) mcnt = 1;
            else if (mcnt != 16'hFFFF) mcnt++;
        end else if (clr) begin
            movf = 1'b0;
            mcnt = 0;
        end
        mlevel = mlevel + (acc ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rd_en     = 1'b0;
        ovf_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        in_valid = 0; in_i = '0; in_q = '0; rd_en = 0; ovf_clear = 0;

        // 1: reset values, single write/read
        do_reset();
        check("rst_rd_dr", 32'(rd_dr), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_afull", 32'(afull), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        step(1, 16'h1234, 16'hABCD, 0, 0);
        check("t1_rd_dr", 32'(rd_dr), 32'd1);
        check("t1_level", 32'(level), 32'd1);
`ifdef IQ_TEST_PATTERN_EN
        check("t1_data", rd_data, 32'h0000FFFF);
`else
        check("t1_data", rd_data, 32'h1234ABCD);
`endif
        step(0, '0, '0, 1, 0);
        check("t1_pop_rd_dr", 32'(rd_dr), 32'd0);
        check("t1_pop_level", 32'(level), 32'd0);
        step(0, '0, '0, 1, 0);
        check("empty_rd_ignored", 32'(level), 32'd0);

        // 2: fill to full, afull threshold, overflow on the 1025th sample
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 16'(k), ~16'(k), 0, 0);
            if (k == 894) check("afull_895", 32'(afull), 32'd0);
            if (k == 895) check("afull_896", 32'(afull), 32'd1);
        end
        check("full_level", 32'(level), 32'd1024);
        check("full_overflow_clear", 32'(overflow), 32'd0);
        step(1, 16'hDEAD, 16'hBEEF, 0, 0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count_1", 32'(ovf_count), 32'd1);
        check("ovf_level", 32'(level), 32'd1024);
`ifndef IQ_TEST_PATTERN_EN
        check("full_head", rd_data, 32'h0000FFFF);
`endif

        // 3: full with simultaneous pop
        step(1, 16'h5555, 16'h5555, 1, 0);
        check("fullpop_level", 32'(level), 32'd1023);
        check("fullpop_count", 32'(ovf_count), 32'd2);
`ifndef IQ_TEST_PATTERN_EN
        check("fullpop_head", rd_data, 32'h0001FFFE);
`endif
        check("fullpop_head_model", rd_data, mq[0]);

        // overflow clear: drop wins, then plain clear
        step(1, 16'h0400, 16'hFBFF, 0, 0);
        check("refill_level", 32'(level), 32'd1024);
        step(1, 16'h7777, 16'h8888, 0, 1);
        check("clr_drop_flag", 32'(overflow), 32'd1);
        check("clr_drop_count", 32'(ovf_count), 32'd1);
        step(0, '0, '0, 0, 1);
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_count", 32'(ovf_count), 32'd0);

        // drain, checking order
        while (mlevel > 0) step(0, '0, '0, 1, 0);
        check("drain_level", 32'(level), 32'd0);
        check("drain_rd_dr", 32'(rd_dr), 32'd0);

        // 4: empty with simultaneous write and read
        step(1, 16'hCAFE, 16'h0042, 1, 0);
        check("t4_level", 32'(level), 32'd1);
        check("t4_data", rd_data, mq[0]);
`ifndef IQ_TEST_PATTERN_EN
        check("t4_data_const", rd_data, 32'hCAFE0042);
`endif
        step(0, '0, '0, 1, 0);

        // 5: long stream with pointer wrap, then asynchronous reset
        for (int k = 0; k < 3000; k++)
            step(1, 16'(k * 7 + 3), 16'(k ^ 16'h5A5A), (k % 4) == 3, 0);
        check("t5_level", 32'(level), 32'(mlevel));
        check("t5_ovf_count", 32'(ovf_count), 32'(mcnt));
        in_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd_dr", 32'(rd_dr), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_level", 32'(level), 32'd0);

`ifdef IQ_TEST_PATTERN_EN
        // 6: ramp pattern after reset
        for (int k = 0; k < 5; k++) step(1, 16'h1111, 16'h2222, 0, 0);
        for (int k = 0; k < 5; k++) begin
            logic [15:0] r;
            r = 16'(k);
            check("pattern_word", rd_data, {r, ~r});
            step(0, '0, '0, 1, 0);
        end
        check("pattern_level", 32'(level), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
